scale_ctrl: RTL and testbench

Controller that sequences the camera display scaler. It debounces a user button to cycle the zoom mode and commits the new mode only at a frame boundary, so no frame mixes two scales. It also generates the frame-buffer read address and an in-window flag for the current pixel (hcount/vcount), using pixel replication. Sits between the video timing generator, the 240x320 camera frame buffer (read port) and the scaler that blanks pixels outside the window.

---
 rtl/scale_pkg.sv | 35 +++
 rtl/scale_ctrl_debounce.sv | 51 +++++
 rtl/scale_ctrl.sv | 130 +++++++++++++
 tb/tb_scale_ctrl.sv | 348 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/scale_pkg.sv
// Shared types and constants for the display scale controller.
//   scale_t      : zoom mode encoding driven to the scaler
//   BUF_W/BUF_H  : camera frame-buffer geometry (240 x 320)
//   ADDR_W       : frame-buffer read address width
//   H_MAX_*/V_MAX_* : last in-window hcount/vcount per mode
//   next_scale() : zoom cycling order 1x -> 2x -> 8/3x -> 1x
package scale_pkg;

  typedef enum logic [1:0] {
    SCALE_1X   = 2'b00,
    SCALE_2X   = 2'b01,
    SCALE_8_3X = 2'b10,
    SCALE_RSVD = 2'b11
  } scale_t;

  localparam int unsigned BUF_W  = 240;
  localparam int unsigned BUF_H  = 320;
  localparam int unsigned ADDR_W = 17;

  localparam int unsigned H_MAX_1X   = 239;
  localparam int unsigned V_MAX_1X   = 319;
  localparam int unsigned H_MAX_2X   = 479;
  localparam int unsigned V_MAX_2X   = 639;
  localparam int unsigned H_MAX_8_3X = 639;
  localparam int unsigned V_MAX_8_3X = 852;

  function automatic scale_t next_scale(input scale_t cur);
    case (cur)
      SCALE_1X: next_scale = SCALE_2X;
      SCALE_2X: next_scale = SCALE_8_3X;
      default:  next_scale = SCALE_1X;
    endcase
  endfunction

endpackage

// File: rtl/scale_ctrl_debounce.sv
// Zoom button conditioner: 2-flop synchronizer, consecutive-cycle debounce
// and rising-edge press detector.
//   clk_in      : pixel clock
//   rst_in      : asynchronous active-low reset
//   btn_in      : raw asynchronous button, 1 = pressed
//   press_pulse : one-cycle pulse when the debounced level goes 0 -> 1
module scale_ctrl_debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic clk_in,
  input  logic rst_in,
  input  logic btn_in,
  output logic press_pulse
);

  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             sync1;
  logic             sync2;
  logic             stable;
  logic [CNT_W-1:0] cnt;

  // The counter only runs while the synced level disagrees with the stable
  // level; any cycle of agreement (a glitch back) clears it.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      sync1       <= 1'b0;
      sync2       <= 1'b0;
      stable      <= 1'b0;
      cnt         <= '0;
      press_pulse <= 1'b0;
    end else begin
      sync1       <= btn_in;
      sync2       <= sync1;
      press_pulse <= 1'b0;
      if (sync2 != stable) begin
        if (cnt == CNT_LAST) begin
          stable      <= sync2;
          cnt         <= '0;
          press_pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/scale_ctrl.sv
// Camera display scale controller. Cycles the zoom mode on debounced
// button presses, commits it only at frame start, and produces the
// frame-buffer read address plus an in-window flag for each pixel.
//   clk_in        : pixel clock
//   rst_in        : asynchronous active-low reset
//   btn_in        : raw zoom button, 1 = pressed
//   new_frame_in  : one-cycle pulse at start of frame (in blanking)
//   hcount_in     : current horizontal pixel
//   vcount_in     : current vertical line
//   scale_out     : committed mode (00 1x, 01 2x, 10 8/3x)
//   pending_out   : requested mode differs from scale_out
//   addr_out      : read address sy*240 + sx, 2 cycles after hcount/vcount
//   in_window_out : pixel lies inside the current mode's window
module scale_ctrl
  import scale_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = 1_000_000
) (
  input  logic              clk_in,
  input  logic              rst_in,
  input  logic              btn_in,
  input  logic              new_frame_in,
  input  logic [10:0]       hcount_in,
  input  logic [9:0]        vcount_in,
  output logic [1:0]        scale_out,
  output logic              pending_out,
  output logic [ADDR_W-1:0] addr_out,
  output logic              in_window_out
);

  logic   press;
  scale_t scale_q;
  scale_t scale_d;
  scale_t target_q;
  scale_t target_d;

  scale_ctrl_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_debounce (
    .clk_in     (clk_in),
    .rst_in     (rst_in),
    .btn_in     (btn_in),
    .press_pulse(press)
  );

  // Commit reads the old target, so a press landing on the frame pulse
  // is deferred to the following frame.
  always_comb begin
    scale_d  = scale_q;
    target_d = target_q;
    if (new_frame_in) scale_d = target_q;
    if (press) target_d = next_scale(target_q);
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      scale_q     <= SCALE_1X;
      target_q    <= SCALE_1X;
      pending_out <= 1'b0;
    end else begin
      scale_q     <= scale_d;
      target_q    <= target_d;
      pending_out <= (target_d != scale_d);
    end
  end

  assign scale_out = scale_q;

  // Stage 1: window check and source coordinates in the committed mode.
  logic [12:0] h3;
  logic [11:0] v3;
  logic        win_d;
  logic [7:0]  sx_d;
  logic [8:0]  sy_d;
  logic        win1;
  logic [7:0]  sx1;
  logic [8:0]  sy1;

  always_comb begin
    h3    = ({2'b00, hcount_in} << 1) + {2'b00, hcount_in};
    v3    = ({2'b00, vcount_in} << 1) + {2'b00, vcount_in};
    win_d = 1'b0;
    sx_d  = '0;
    sy_d  = '0;
    case (scale_q)
      SCALE_1X: begin
        win_d = (hcount_in <= 11'(H_MAX_1X)) && (vcount_in <= 10'(V_MAX_1X));
        sx_d  = 8'(hcount_in);
        sy_d  = 9'(vcount_in);
      end
      SCALE_2X: begin
        win_d = (hcount_in <= 11'(H_MAX_2X)) && (vcount_in <= 10'(V_MAX_2X));
        sx_d  = 8'(hcount_in >> 1);
        sy_d  = 9'(vcount_in >> 1);
      end
      SCALE_8_3X: begin
        win_d = (hcount_in <= 11'(H_MAX_8_3X)) && (vcount_in <= 10'(V_MAX_8_3X));
        sx_d  = 8'(h3 >> 3);
        sy_d  = 9'(v3 >> 3);
      end
      default: win_d = 1'b0;
    endcase
    // Truncated coordinates are only meaningful inside the window.
    if (!win_d) begin
      sx_d = '0;
      sy_d = '0;
    end
  end

  // Stage 2: sy*240 + sx as sy*256 - sy*16 + sx.
  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      win1          <= 1'b0;
      sx1           <= '0;
      sy1           <= '0;
      addr_out      <= '0;
      in_window_out <= 1'b0;
    end else begin
      win1          <= win_d;
      sx1           <= sx_d;
      sy1           <= sy_d;
      in_window_out <= win1;
      if (win1)
        addr_out <= {sy1, 8'b0} - {4'b0, sy1, 4'b0} + {9'b0, sx1};
      else
        addr_out <= '0;
    end
  end

endmodule

// File: tb/tb_scale_ctrl.sv
module tb_scale_ctrl;

  localparam int DEB = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b1;
  logic        btn = 1'b0;
  logic        nf = 1'b0;
  logic [10:0] h = '0;
  logic [9:0]  v = '0;
  logic [1:0]  scale;
  logic        pend;
  logic [16:0] addr;
  logic        inwin;

  int unsigned passed = 0;
  int unsigned total = 0;

  // Reference state: requested and committed zoom mode as 0/1/2.
  int m_target = 0;
  int m_scale  = 0;

  scale_ctrl #(.DEBOUNCE_CYCLES(DEB)) dut (
    .clk_in       (clk),
    .rst_in       (rst_n),
    .btn_in       (btn),
    .new_frame_in (nf),
    .hcount_in    (h),
    .vcount_in    (v),
    .scale_out    (scale),
    .pending_out  (pend),
    .addr_out     (addr),
    .in_window_out(inwin)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  function automatic bit ref_win(input int mode, input int hh, input int vv);
    case (mode)
      0: return (hh < 240) && (vv < 320);
      1: return (hh < 480) && (vv < 640);
      2: return (hh < 640) && (vv < 853);
      default: return 1'b0;
    endcase
  endfunction

  function automatic int ref_addr(input int mode, input int hh, input int vv);
    int sx, sy;
    if (!ref_win(mode, hh, vv)) return 0;
    case (mode)
      0: begin sx = hh; sy = vv; end
      1: begin sx = hh / 2; sy = vv / 2; end
      default: begin sx = (hh * 3) / 8; sy = (vv * 3) / 8; end
    endcase
    return sy * 240 + sx;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_press();
    btn = 1'b1;
    repeat (10) tick();
    btn = 1'b0;
    repeat (10) tick();
    m_target = (m_target + 1) % 3;
  endtask

  task automatic do_frame();
    nf = 1'b1;
    tick();
    nf = 1'b0;
    m_scale = m_target;
    tick();
  endtask

  task automatic goto_mode(input int m);
    while (m_scale != m) begin
      while (m_target != m) do_press();
      do_frame();
    end
  endtask

  task automatic test_reset();
    h = 11'd2000;
    v = 10'd1000;
    #1 rst_n = 1'b0;
    for (int i = 0; i < 20; i++) begin
      btn = 1'($urandom);
      nf  = 1'($urandom);
      tick();
      if (i % 5 == 4) begin
        @(negedge clk);
        total++;
        if (scale !== 2'b00 || pend !== 1'b0 || addr !== 17'd0 || inwin !== 1'b0)
          $display("FAIL reset_hold: scale=%b pend=%b addr=%0d inwin=%b, want 00 0 0 0",
                   scale, pend, addr, inwin);
        else passed++;
      end
    end
    btn = 1'b0;
    nf  = 1'b0;
    tick();
    rst_n = 1'b1;
    m_target = 0;
    m_scale  = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (i % 100 == 99) begin
        @(negedge clk);
        total++;
        if (scale !== 2'b00 || pend !== 1'b0 || addr !== 17'd0 || inwin !== 1'b0)
          $display("FAIL reset_idle: scale=%b pend=%b addr=%0d inwin=%b, want 00 0 0 0",
                   scale, pend, addr, inwin);
        else passed++;
      end
    end
  endtask

  task automatic test_debounce();
    // Pulses of at most DEB-1 cycles, random gaps: never a press.
    for (int i = 0; i < 20; i++) begin
      btn = 1'b1;
      repeat ($urandom_range(1, DEB - 1)) tick();
      btn = 1'b0;
      repeat ($urandom_range(1, 6)) tick();
    end
    repeat (10) tick();
    @(negedge clk);
    total++;
    if (pend !== 1'b0) $display("FAIL glitch_pending: pend=%b, want 0", pend);
    else passed++;
    // 3-cycle pulse explicitly.
    btn = 1'b1;
    repeat (3) tick();
    btn = 1'b0;
    repeat (12) tick();
    @(negedge clk);
    total++;
    if (pend !== 1'b0) $display("FAIL short_pulse_pending: pend=%b, want 0", pend);
    else passed++;
    // 10-cycle pulse: exactly one press.
    do_press();
    @(negedge clk);
    total++;
    if (pend !== 1'b1 || scale !== 2'b00)
      $display("FAIL press_pending: pend=%b scale=%b, want 1 00", pend, scale);
    else passed++;
    repeat (20) tick();
    @(negedge clk);
    total++;
    if (scale !== 2'b00) $display("FAIL press_no_commit: scale=%b, want 00", scale);
    else passed++;
    do_frame();
    @(negedge clk);
    total++;
    if (scale !== 2'b01 || pend !== 1'b0)
      $display("FAIL press_commit: scale=%b pend=%b, want 01 0", scale, pend);
    else passed++;
  endtask

  task automatic test_addr(input int mode);
    int hs[$], vs[$], ea[$], ew[$];
    int n;
    goto_mode(mode);
    // Directed boundary points with hand-derived expectations.
    case (mode)
      0: begin
        hs = '{239, 240, 0, 239, 100};
        vs = '{319, 0, 0, 320, 10};
        ea = '{76799, 0, 0, 0, 2500};
        ew = '{1, 0, 1, 0, 1};
      end
      1: begin
        hs = '{101, 479, 480, 0, 479};
        vs = '{51, 639, 0, 640, 0};
        ea = '{6050, 76799, 0, 0, 239};
        ew = '{1, 1, 0, 0, 1};
      end
      default: begin
        hs = '{639, 8, 640, 0, 0};
        vs = '{852, 8, 0, 853, 852};
        ea = '{76799, 723, 0, 0, 76560};
        ew = '{1, 1, 0, 0, 1};
      end
    endcase
    for (int i = 0; i < 40; i++) begin
      int hh, vv;
      hh = $urandom_range(0, 700);
      vv = $urandom_range(0, 900);
      hs.push_back(hh);
      vs.push_back(vv);
      ea.push_back(ref_addr(mode, hh, vv));
      ew.push_back(int'(ref_win(mode, hh, vv)));
    end
    n = hs.size();
    for (int i = 0; i < n + 2; i++) begin
      tick();
      if (i < n) begin
        h = 11'(hs[i]);
        v = 10'(vs[i]);
      end else begin
        h = 11'd2000;
        v = 10'd1000;
      end
      @(negedge clk);
      if (i >= 2) begin
        total++;
        if (addr !== 17'(ea[i-2]) || inwin !== 1'(ew[i-2]))
          $display("FAIL addr_mode%0d (h=%0d v=%0d): addr=%0d inwin=%b, want %0d %0d",
                   mode, hs[i-2], vs[i-2], addr, inwin, ea[i-2], ew[i-2]);
        else passed++;
      end
    end
  endtask

  task automatic test_sequencing();
    goto_mode(0);
    do_press();
    @(negedge clk);
    total++;
    if (pend !== 1'b1 || scale !== 2'b00)
      $display("FAIL seq_pre: pend=%b scale=%b, want 1 00", pend, scale);
    else passed++;
    // The press pulse reaches the mode logic after 2 sync + DEB debounce
    // cycles plus the pulse register: frame pulse placed in that cycle.
    btn = 1'b1;
    repeat (2 + DEB) tick();
    nf = 1'b1;
    tick();
    nf = 1'b0;
    m_scale  = 1;
    m_target = 2;
    @(negedge clk);
    total++;
    if (scale !== 2'b01 || pend !== 1'b1)
      $display("FAIL seq_coincident: scale=%b pend=%b, want 01 1", scale, pend);
    else passed++;
    repeat (4) tick();
    btn = 1'b0;
    repeat (10) tick();
    @(negedge clk);
    total++;
    if (scale !== 2'b01 || pend !== 1'b1)
      $display("FAIL seq_after_release: scale=%b pend=%b, want 01 1", scale, pend);
    else passed++;
    do_frame();
    @(negedge clk);
    total++;
    if (scale !== 2'b10 || pend !== 1'b0)
      $display("FAIL seq_deferred_commit: scale=%b pend=%b, want 10 0", scale, pend);
    else passed++;
    // Three presses in one frame wrap back to the committed mode.
    do_press();
    @(negedge clk);
    total++;
    if (pend !== 1'b1) $display("FAIL triple_first: pend=%b, want 1", pend);
    else passed++;
    do_press();
    do_press();
    @(negedge clk);
    total++;
    if (pend !== 1'b0) $display("FAIL triple_wrap: pend=%b, want 0", pend);
    else passed++;
    do_frame();
    @(negedge clk);
    total++;
    if (scale !== 2'b10 || pend !== 1'b0)
      $display("FAIL triple_commit: scale=%b pend=%b, want 10 0", scale, pend);
    else passed++;
  endtask

  task automatic test_reset_mid_press();
    btn = 1'b1;
    repeat (3) tick();
    rst_n = 1'b0;
    tick();
    @(negedge clk);
    total++;
    if (scale !== 2'b00 || pend !== 1'b0 || addr !== 17'd0 || inwin !== 1'b0)
      $display("FAIL midpress_reset: scale=%b pend=%b addr=%0d inwin=%b, want 00 0 0 0",
               scale, pend, addr, inwin);
    else passed++;
    tick();
    rst_n = 1'b1;
    m_target = 0;
    m_scale  = 0;
    repeat (12) tick();
    @(negedge clk);
    total++;
    if (pend !== 1'b1 || scale !== 2'b00)
      $display("FAIL midpress_held: pend=%b scale=%b, want 1 00", pend, scale);
    else passed++;
    btn = 1'b0;
    repeat (10) tick();
    m_target = 1;
    do_frame();
    @(negedge clk);
    total++;
    if (scale !== 2'b01 || pend !== 1'b0)
      $display("FAIL midpress_commit: scale=%b pend=%b, want 01 0", scale, pend);
    else passed++;
  endtask

  task automatic test_random_sequence();
    for (int i = 0; i < 40; i++) begin
      case ($urandom_range(0, 3))
        0, 1: do_press();
        2: do_frame();
        default: begin
          btn = 1'b1;
          repeat ($urandom_range(1, DEB - 1)) tick();
          btn = 1'b0;
          repeat (8) tick();
        end
      endcase
      @(negedge clk);
      total++;
      if (scale !== 2'(m_scale) || pend !== 1'(m_target != m_scale))
        $display("FAIL random_seq step %0d: scale=%b pend=%b, want %0d %0d",
                 i, scale, pend, m_scale, int'(m_target != m_scale));
      else passed++;
    end
  endtask

  initial begin
    test_reset();
    test_debounce();
    test_addr(0);
    test_addr(1);
    test_addr(2);
    test_sequencing();
    test_reset_mid_press();
    test_random_sequence();
    test_addr(m_target);
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
